// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner: scans a 4x4 hex keypad one column at a time, debounces presses and releases, and hands each key over through valid/ack
// Ports:
//   CLK100MHZ   system clock, rising edge
//   CPU_RESETN  asynchronous active-low reset
//   ROW         active-low keypad rows (asynchronous, synchronized here)
//   COL         active-low column drive, exactly one column low
//   key_code    hex value of the last accepted key
//   key_valid   key_code is new, held until key_ack
//   key_ack     consumer acknowledge, only meaningful while key_valid
//   key_overrun sticky: a key was accepted before the previous one was acknowledged
//   data        {previous nibble, newest nibble}, shifted on every accepted key
module hex_keypad_scanner #(
  parameter int SCAN_DIV       = 13,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_overrun,
  output logic [7:0] data
);
  localparam int DW = $clog2(DEBOUNCE_SCANS);
  // nibble {row,col} of the Pmod KYPD layout, row 0 / col 0 in the lowest nibble
  localparam logic [63:0] KEYS = 64'hDEF0_C987_B654_A321;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, ACCEPT, RELEASE} state_t;
  state_t state, state_d;
  logic [3:0] row_m, row_s, lat_row, lat_d, key;
  logic [SCAN_DIV-1:0] cnt;
  logic [1:0] col, col_d, row_idx;
  logic [DW-1:0] deb_cnt, deb_d;
  logic tick, deb_last;
  assign tick = cnt == '0;
  assign deb_last = deb_cnt == DW'(DEBOUNCE_SCANS - 1);
  // several rows low in the frozen column: the lowest row index wins
  assign row_idx = !lat_row[0] ? 2'd0 : !lat_row[1] ? 2'd1 : !lat_row[2] ? 2'd2 : 2'd3;
  assign key = KEYS[{row_idx, col, 2'b00} +: 4];
  assign COL = ~(4'b0001 << col);
  always_comb begin
    state_d = state;
    col_d = col;
    lat_d = lat_row;
    deb_d = deb_cnt;
    case (state)
      SCAN:
        if (tick) begin
          if (row_s == 4'hF) col_d = col + 2'd1;
          else begin
            lat_d = row_s;
            deb_d = '0;
            state_d = DEBOUNCE;
          end
        end
      DEBOUNCE:
        if (tick) begin
          if (row_s != lat_row) state_d = SCAN;
          else if (deb_last) state_d = ACCEPT;
          else deb_d = deb_cnt + 1'b1;
        end
      ACCEPT: begin
        deb_d = '0;
        state_d = RELEASE;
      end
      default:
        if (tick) begin
          if (row_s != 4'hF) deb_d = '0;
          else if (deb_last) state_d = SCAN;
          else deb_d = deb_cnt + 1'b1;
        end
    endcase
  end
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
      cnt <= '0;
      state <= SCAN;
      col <= 2'd0;
      lat_row <= 4'hF;
      deb_cnt <= '0;
      key_code <= 4'h0;
      key_valid <= 1'b0;
      key_overrun <= 1'b0;
      data <= 8'h00;
    end else begin
      row_m <= ROW;
      row_s <= row_m;
      cnt <= cnt + 1'b1;
      state <= state_d;
      col <= col_d;
      lat_row <= lat_d;
      deb_cnt <= deb_d;
      if (state == ACCEPT) begin
        key_code <= key;
        data <= {data[3:0], key};
        key_valid <= 1'b1;
        key_overrun <= key_overrun | (key_valid & ~key_ack);
      end else if (key_ack) key_valid <= 1'b0;
    end
  end
endmodule
